// File: rtl/ast_pkg.sv
// Shared constants and helpers for the round-robin arbiter tree.
package ast_pkg;

  // Default payload width: address + data + control.
  localparam int AST_DATA_WIDTH = 132;

  // Ceiling log2, used for constant index widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/ast_rr_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the downstream sink.
//
// Handshake: requester i holds req[i] and its d_in slice until it sees serv[i] (one-hot,
// combinational, valid in the capture cycle). On the output side, d_out is transferred in
// every cycle where out_valid && out_ready are both high; while out_valid && !out_ready,
// d_out and out_valid are held.
interface ast_rr_arbiter_if #(
  parameter int SWITCH_BITS = 3,
  parameter int DATA_WIDTH  = 132
);
  localparam int N = 1 << SWITCH_BITS;

  logic [N-1:0]            req;
  logic [N*DATA_WIDTH-1:0] d_in;
  logic [N-1:0]            serv;
  logic [DATA_WIDTH-1:0]   d_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    active;

  // Requester and sink side.
  modport master (
    output req, d_in, out_ready,
    input  serv, d_out, out_valid, active
  );

  // Arbiter side.
  modport slave (
    input  req, d_in, out_ready,
    output serv, d_out, out_valid, active
  );

endinterface

// File: rtl/ast_rr_node.sv
// Two-input priority node with a fairness flop. The flop names the side that wins the next
// conflict (0 = a, 1 = b); upd is raised only for a contested node on the winner's path in a
// load cycle, and then hands priority to the side that lost.
module ast_rr_node (
  input  logic clk,
  input  logic rst,
  input  logic a_act,
  input  logic b_act,
  input  logic upd,
  output logic act,
  output logic pick_b,
  output logic conflict
);

  logic flop;

  // Pick the flop's side on conflict, otherwise whichever child is active.
  always_comb begin
    act      = a_act | b_act;
    conflict = a_act & b_act;
    pick_b   = conflict ? flop : b_act;
  end

  // After serving one side of a conflict, favour the other side next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      flop <= 1'b0;
    end else if (upd) begin
      flop <= ~pick_b;
    end
  end

endmodule

// File: rtl/ast_rr_arbiter.sv
// Round-robin arbiter for 2**SWITCH_BITS requesters built as a heap-indexed tree of
// ast_rr_node (nodes 1..N-1, leaves N..2N-1 = requesters 0..N-1), with a registered
// output stage under valid/ready backpressure.
module ast_rr_arbiter
  import ast_pkg::*;
#(
  parameter int SWITCH_BITS = 3,
  parameter int DATA_WIDTH  = AST_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  ast_rr_arbiter_if.slave  bus
);

  localparam int N     = 1 << SWITCH_BITS;
  localparam int IDX_W = clog2(N);

  logic [N-1:1]          pick_b;
  logic [N-1:1]          conflict;
  logic [N-1:1]          on_path;
  logic [IDX_W-1:0]      win_idx;
  logic                  load;
  logic [DATA_WIDTH-1:0] win_data;

  // Node tree; each node's children are either two sub-nodes or two requesters.
  for (genvar k = 1; k < N; k++) begin : g_node
    logic a_act;
    logic b_act;
    logic act;
    logic upd;

    if (2 * k >= N) begin : g_leaf
      assign a_act = bus.req[2*k-N];
      assign b_act = bus.req[2*k+1-N];
    end else begin : g_inner
      assign a_act = g_node[2*k].act;
      assign b_act = g_node[2*k+1].act;
    end

    assign upd = load & on_path[k] & conflict[k];

    ast_rr_node u_node (
      .clk      (clk),
      .rst      (rst),
      .a_act    (a_act),
      .b_act    (b_act),
      .upd      (upd),
      .act      (act),
      .pick_b   (pick_b[k]),
      .conflict (conflict[k])
    );
  end

  assign bus.active = g_node[1].act;
  assign load       = bus.active & (~bus.out_valid | bus.out_ready) & ~rst;

  // Walk from the root following each node's pick; the final heap index minus N is the winner.
  always_comb begin
    logic [IDX_W:0] node;
    on_path = '0;
    node    = {{IDX_W{1'b0}}, 1'b1};
    for (int l = 0; l < IDX_W; l++) begin
      on_path[node[IDX_W-1:0]] = 1'b1;
      node = {node[IDX_W-1:0], pick_b[node[IDX_W-1:0]]};
    end
    win_idx = node[IDX_W-1:0];
  end

  // One-hot accept strobe, only in a capture cycle.
  always_comb begin
    bus.serv = '0;
    if (load) bus.serv[win_idx] = 1'b1;
  end

  // N:1 payload mux on the winner index.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IDX_W'(i)) win_data = bus.d_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output register: capture on load, release when the sink takes it with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.d_out     <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.d_out     <= win_data;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
